// File: rtl/burst_slave_port_pkg.sv
// Shared definitions for the burst serial-bus slave port: FSM encoding,
// beat-count arithmetic and a parameter-legality helper.
package burst_slave_port_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_WDATA  = 4'd2,
    ST_MWRITE = 4'd3,
    ST_MREAD  = 4'd4,
    ST_RWAIT  = 4'd5,
    ST_SPLIT  = 4'd6,
    ST_SWAIT  = 4'd7,
    ST_RDATA  = 4'd8
  } state_e;

  // Number of serial beats needed to move a field of the given width.
  function automatic int unsigned beat_count(input int unsigned width, input int unsigned lane_w);
    return width / lane_w;
  endfunction

  // A configuration is usable when every field is a whole number of lanes
  // and the split hold time is at least one cycle.
  function automatic bit cfg_legal(input int unsigned addr_w, input int unsigned data_w,
                                   input int unsigned lane_w, input int unsigned split_lat);
    return (lane_w > 0) && (addr_w >= lane_w) && (data_w >= lane_w) &&
           ((addr_w % lane_w) == 0) && ((data_w % lane_w) == 0) && (split_lat >= 1);
  endfunction

endpackage

// File: rtl/burst_slave_port_lane_shift_reg.sv
// Lane shifter used both as SIPO (address / write data receive) and PISO
// (read data transmit). New lanes enter at the top so the first beat ends up
// in the least significant lane; the transmit side always presents the
// least significant lane.
module lane_shift_reg #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LANE_W = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              shift,
  input  logic [LANE_W-1:0] lane_in,
  input  logic [WIDTH-1:0]  par_in,
  output logic [WIDTH-1:0]  par_out,
  output logic [LANE_W-1:0] lane_out
);

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] shifted_s;

  if (WIDTH == LANE_W) begin : g_single
    assign shifted_s = lane_in;
  end else begin : g_multi
    assign shifted_s = {lane_in, data_r[WIDTH-1:LANE_W]};
  end

  // Parallel load has priority over shifting; otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= par_in;
    end else if (shift) begin
      data_r <= shifted_s;
    end else begin
      data_r <= data_r;
    end
  end

  assign par_out  = data_r;
  assign lane_out = data_r[LANE_W-1:0];

endmodule

// File: rtl/burst_slave_port.sv
// Serial-bus slave endpoint with incrementing bursts and optional split reads.
// FSM and counters live here; lane shifters handle the serial/parallel
// conversion for address, write data and read data.
module burst_slave_port
  import burst_slave_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LANE_W        = 1,
  parameter int unsigned LEN_WIDTH     = 4,
  parameter bit          SPLIT_EN      = 1'b0,
  parameter int unsigned SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  rvalid,
  output logic                  smemwen,
  output logic                  smemren,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  input  logic [LANE_W-1:0]     swdata,
  input  logic                  smode,
  input  logic [LEN_WIDTH-1:0]  sburst_len,
  input  logic                  mvalid,
  input  logic                  split_grant,
  output logic [LANE_W-1:0]     srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  output logic                  sdone
);

  localparam bit          CFG_OK = cfg_legal(ADDR_WIDTH, DATA_WIDTH, LANE_W, SPLIT_LATENCY);
  localparam int unsigned NA     = beat_count(ADDR_WIDTH, LANE_W);
  localparam int unsigned ND     = beat_count(DATA_WIDTH, LANE_W);
  localparam int unsigned MAXB   = (NA > ND) ? NA : ND;
  localparam int unsigned BCW    = $clog2(MAXB + 1);
  localparam int unsigned SCW    = $clog2(SPLIT_LATENCY + 1);

  localparam logic [BCW-1:0] BEAT_ONE  = BCW'(1);
  localparam logic [BCW-1:0] BEAT_ZERO = BCW'(0);
  localparam logic [BCW-1:0] NA_LAST   = BCW'(NA - 1);
  localparam logic [BCW-1:0] ND_LAST   = BCW'(ND - 1);
  localparam logic [SCW-1:0] SPL_LAST  = SCW'(SPLIT_LATENCY - 1);

  if (!CFG_OK) begin : g_cfg_check
    $error("burst_slave_port: ADDR_WIDTH/DATA_WIDTH must be multiples of LANE_W and SPLIT_LATENCY >= 1");
  end

  state_e                state_r, state_nxt_s;
  logic [BCW-1:0]        beat_cnt_r, beat_nxt_s;
  logic [LEN_WIDTH-1:0]  word_cnt_r, word_nxt_s;
  logic [SCW-1:0]        split_cnt_r, split_nxt_s;
  logic                  latched_r, latched_nxt_s;
  logic                  mode_r;
  logic [LEN_WIDTH-1:0]  len_r;

  logic addr_shift_s, addr_load_s, wd_shift_s, tx_load_s, tx_shift_s;
  logic smemwen_nxt_s, smemren_nxt_s, svalid_nxt_s, sdone_nxt_s;
  logic smemwen_r, smemren_r, svalid_r, sdone_r;

  logic [ADDR_WIDTH-1:0] addr_s, addr_inc_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [LANE_W-1:0]     addr_lane_unused_s, wd_lane_unused_s;
  logic [DATA_WIDTH-1:0] tx_par_unused_s;

  assign addr_inc_s = addr_s + ADDR_WIDTH'(1);

  lane_shift_reg #(.WIDTH(ADDR_WIDTH), .LANE_W(LANE_W)) u_addr_rx (
    .clk(clk), .rstn(rstn), .load(addr_load_s), .shift(addr_shift_s),
    .lane_in(swdata), .par_in(addr_inc_s), .par_out(addr_s), .lane_out(addr_lane_unused_s)
  );

  lane_shift_reg #(.WIDTH(DATA_WIDTH), .LANE_W(LANE_W)) u_wdata_rx (
    .clk(clk), .rstn(rstn), .load(1'b0), .shift(wd_shift_s),
    .lane_in(swdata), .par_in({DATA_WIDTH{1'b0}}), .par_out(wdata_s), .lane_out(wd_lane_unused_s)
  );

  lane_shift_reg #(.WIDTH(DATA_WIDTH), .LANE_W(LANE_W)) u_rdata_tx (
    .clk(clk), .rstn(rstn), .load(tx_load_s), .shift(tx_shift_s),
    .lane_in({LANE_W{1'b0}}), .par_in(smemrdata), .par_out(tx_par_unused_s), .lane_out(srdata)
  );

  // State, counters and the split data-latched flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= BEAT_ZERO;
      word_cnt_r  <= {LEN_WIDTH{1'b0}};
      split_cnt_r <= {SCW{1'b0}};
      latched_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      beat_cnt_r  <= beat_nxt_s;
      word_cnt_r  <= word_nxt_s;
      split_cnt_r <= split_nxt_s;
      latched_r   <= latched_nxt_s;
    end
  end

  // Direction and burst length are captured with the first address beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_r <= 1'b0;
      len_r  <= {LEN_WIDTH{1'b0}};
    end else if ((state_r == ST_IDLE) && mvalid) begin
      mode_r <= smode;
      len_r  <= sburst_len;
    end else begin
      mode_r <= mode_r;
      len_r  <= len_r;
    end
  end

  // Next-state, counter updates and shifter controls.
  always_comb begin
    state_nxt_s   = state_r;
    beat_nxt_s    = beat_cnt_r;
    word_nxt_s    = word_cnt_r;
    split_nxt_s   = split_cnt_r;
    latched_nxt_s = latched_r;
    addr_shift_s  = 1'b0;
    addr_load_s   = 1'b0;
    wd_shift_s    = 1'b0;
    tx_load_s     = 1'b0;
    tx_shift_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mvalid) begin
          addr_shift_s = 1'b1;
          word_nxt_s   = {LEN_WIDTH{1'b0}};
          if (NA == 1) begin
            beat_nxt_s  = BEAT_ZERO;
            state_nxt_s = smode ? ST_WDATA : ST_MREAD;
          end else begin
            beat_nxt_s  = BEAT_ONE;
            state_nxt_s = ST_ADDR;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (mvalid) begin
          addr_shift_s = 1'b1;
          if (beat_cnt_r == NA_LAST) begin
            beat_nxt_s  = BEAT_ZERO;
            state_nxt_s = mode_r ? ST_WDATA : ST_MREAD;
          end else begin
            beat_nxt_s = beat_cnt_r + BEAT_ONE;
          end
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_WDATA: begin
        if (mvalid) begin
          wd_shift_s = 1'b1;
          if (beat_cnt_r == ND_LAST) begin
            beat_nxt_s  = BEAT_ZERO;
            state_nxt_s = ST_MWRITE;
          end else begin
            beat_nxt_s = beat_cnt_r + BEAT_ONE;
          end
        end else begin
          state_nxt_s = ST_WDATA;
        end
      end
      ST_MWRITE: begin
        if (word_cnt_r == len_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          word_nxt_s  = word_cnt_r + LEN_WIDTH'(1);
          addr_load_s = 1'b1;
          state_nxt_s = ST_WDATA;
        end
      end
      ST_MREAD: begin
        split_nxt_s   = {SCW{1'b0}};
        latched_nxt_s = 1'b0;
        if (SPLIT_EN && (word_cnt_r == {LEN_WIDTH{1'b0}})) begin
          state_nxt_s = ST_SPLIT;
        end else begin
          state_nxt_s = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (rvalid) begin
          tx_load_s   = 1'b1;
          beat_nxt_s  = BEAT_ZERO;
          state_nxt_s = ST_RDATA;
        end else begin
          state_nxt_s = ST_RWAIT;
        end
      end
      ST_SPLIT: begin
        // Keep only the first returned word; the memory issues one per strobe.
        if (rvalid && !latched_r) begin
          tx_load_s     = 1'b1;
          latched_nxt_s = 1'b1;
        end else begin
          latched_nxt_s = latched_r;
        end
        if (split_cnt_r == SPL_LAST) begin
          state_nxt_s = ST_SWAIT;
        end else begin
          split_nxt_s = split_cnt_r + SCW'(1);
        end
      end
      ST_SWAIT: begin
        if (rvalid && !latched_r) begin
          tx_load_s     = 1'b1;
          latched_nxt_s = 1'b1;
        end else begin
          latched_nxt_s = latched_r;
        end
        if (split_grant && (latched_r || rvalid)) begin
          beat_nxt_s  = BEAT_ZERO;
          state_nxt_s = ST_RDATA;
        end else begin
          state_nxt_s = ST_SWAIT;
        end
      end
      ST_RDATA: begin
        tx_shift_s = 1'b1;
        if (beat_cnt_r == ND_LAST) begin
          beat_nxt_s = BEAT_ZERO;
          if (word_cnt_r == len_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            word_nxt_s  = word_cnt_r + LEN_WIDTH'(1);
            addr_load_s = 1'b1;
            state_nxt_s = ST_MREAD;
          end
        end else begin
          beat_nxt_s = beat_cnt_r + BEAT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so strobes come straight from flops.
  always_comb begin
    smemwen_nxt_s = (state_nxt_s == ST_MWRITE);
    smemren_nxt_s = (state_nxt_s == ST_MREAD);
    svalid_nxt_s  = (state_nxt_s == ST_RDATA);
    if ((state_nxt_s == ST_MWRITE) && (word_nxt_s == len_r)) begin
      sdone_nxt_s = 1'b1;
    end else if ((state_nxt_s == ST_RDATA) && (beat_nxt_s == ND_LAST) && (word_nxt_s == len_r)) begin
      sdone_nxt_s = 1'b1;
    end else begin
      sdone_nxt_s = 1'b0;
    end
  end

  // Registered strobes and handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smemwen_r <= 1'b0;
      smemren_r <= 1'b0;
      svalid_r  <= 1'b0;
      sdone_r   <= 1'b0;
    end else begin
      smemwen_r <= smemwen_nxt_s;
      smemren_r <= smemren_nxt_s;
      svalid_r  <= svalid_nxt_s;
      sdone_r   <= sdone_nxt_s;
    end
  end

  assign smemwen   = smemwen_r;
  assign smemren   = smemren_r;
  assign svalid    = svalid_r;
  assign sdone     = sdone_r;
  assign smemaddr  = addr_s;
  assign smemwdata = wdata_s;
  assign sready    = (state_r == ST_IDLE);
  assign ssplit    = (state_r == ST_SPLIT);

endmodule
